adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4: operand width of the shared adder.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-003 SHALL have one clock; reset is asynchronous and active-high: ports clk (input, 1) and rst (input, 1, asynchronous, active-high).
REQ-004 req_valid  input  NUM_REQ  per-requester operation request.
REQ-005 req_a, req_b  input  NUM_REQ*BIT_WIDTH  packed operands; requester i occupies slice [i*BIT_WIDTH +: BIT_WIDTH].
REQ-006 req_cin  input  NUM_REQ  per-requester carry-in.
REQ-007 req_ready  output  NUM_REQ  one-hot grant/accept.
REQ-008 resp_valid  output  1; resp_ready  input  1; resp_sum  output  BIT_WIDTH; resp_ovf  output  1; resp_id  output  clog2(NUM_REQ).
REQ-009 add_a, add_b  output  BIT_WIDTH; add_cin  output  1: operands to the shared registered adder.
REQ-010 add_sum  input  BIT_WIDTH; add_ovf  input  1: adder registered outputs, valid one cycle after operands are presented.
REQ-011 busy  output  1: high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-013 IDLE: if any req_valid, select winner w by round-robin, assert req_ready[w] combinationally that cycle, latch w's operands and id at the edge, go ISSUE; else stay IDLE, req_ready all 0.
REQ-014 req_ready SHALL be 0 in every state except IDLE, and at most one bit high.
REQ-015 Round-robin: search starts at pointer ptr, ascending with wrap from NUM_REQ-1 to 0; after grant to w, ptr <= (w+1) mod NUM_REQ.
REQ-016 add_a/add_b/add_cin SHALL be driven from the latched operand registers in all states.
REQ-017 ISSUE: one cycle, unconditional transition to WAIT (adder captures operands at this edge).
REQ-018 WAIT: capture add_sum/add_ovf into result registers, go RESP.
REQ-019 RESP: resp_valid=1, resp_sum/resp_ovf/resp_id stable; on resp_ready go IDLE; hold indefinitely otherwise.
REQ-020 Latency: acceptance edge in cycle 0 -> resp_valid high in cycle 3; minimum 4 cycles per operation, no new acceptance while busy.
REQ-021 resp_sum SHALL equal (a+b+cin) mod 2^BIT_WIDTH and resp_ovf the carry-out bit (bit BIT_WIDTH of the BIT_WIDTH+1-bit sum).
REQ-022 Requester deasserting req_valid after acceptance SHALL not affect the in-flight operation.
REQ-023 A request with req_valid high at the same cycle RESP completes SHALL wait until IDLE of the following cycle.

Reset
REQ-024 On rst: state=IDLE, ptr=0, operand/result/id registers=0, resp_valid=0, req_ready=0, busy=0, add_a/add_b/add_cin=0.
REQ-025 rst asserted mid-operation SHALL abort it with no response issued; first post-reset grant uses ptr=0.

Structure
REQ-026 State enum and response-tuple struct SHALL live in a shared package adder_arb_pkg.
REQ-027 Round-robin selection SHALL be a sub-module rr_picker (inputs valid vector, ptr; outputs one-hot grant, index, any).
REQ-028 The adder itself is external; arbiter instantiates no adder.

Verification (bench pairs arbiter with adder_nbit, BIT_WIDTH=4, NUM_REQ=4)
REQ-029 Single req0: a=3,b=4,cin=1 -> req_ready[0] in cycle 0, resp_valid cycle 3, sum=8, ovf=0, id=0.
REQ-030 Overflow: a=15,b=1,cin=0 -> sum=0, ovf=1; a=15,b=15,cin=1 -> sum=15, ovf=1.
REQ-031 All four req_valid held high continuously, resp_ready=1 -> grant order 0,1,2,3,0, one grant every 4 cycles.
REQ-032 Backpressure: resp_ready=0 for 10 cycles -> resp_valid and payload stable, req_ready all 0, then completes on first resp_ready.
REQ-033 Wrap: ptr=3 with req1 and req2 valid -> grant req1, then ptr=2.
REQ-034 rst asserted in WAIT -> next cycle IDLE, resp_valid=0, no response for aborted op; following grant to lowest valid index.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// ============================================================================
// Module      : adder_arb_pkg
// Description : Shared types for the adder arbiter: FSM state encoding and the
//               registered response tuple.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_arb_pkg;

    // Response fields are sized for the widest supported configuration;
    // instances use the low-order bits of each field.
    localparam int unsigned c_MAX_BIT_WIDTH = 32;
    localparam int unsigned c_MAX_ID_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [c_MAX_BIT_WIDTH-1:0] sum;
        logic                       ovf;
        logic [c_MAX_ID_W-1:0]      id;
    } resp_t;

    function automatic resp_t pack_resp(
        input logic [c_MAX_BIT_WIDTH-1:0] sum,
        input logic                       ovf,
        input logic [c_MAX_ID_W-1:0]      id
    );
        resp_t r;
        r.sum = sum;
        r.ovf = ovf;
        r.id  = id;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin selector. Searches the valid vector
//               upward from ptr with wrap, returning a one-hot grant + index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    index,
    output logic               any
);

    logic [ID_W-1:0] w_pos;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        w_pos = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && valid[w_pos]) begin
                grant[w_pos] = 1'b1;
                index        = w_pos;
                any          = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin arbiter sharing one external registered adder among
//               NUM_REQ requesters; one operation in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int NUM_REQ   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]           req_cin,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [BIT_WIDTH-1:0]         resp_sum,
    output logic                         resp_ovf,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [BIT_WIDTH-1:0]         add_a,
    output logic [BIT_WIDTH-1:0]         add_b,
    output logic                         add_cin,
    input  logic [BIT_WIDTH-1:0]         add_sum,
    input  logic                         add_ovf,
    output logic                         busy
);

    localparam int c_ID_W = $clog2(NUM_REQ);

    arb_state_t           r_state;
    logic [c_ID_W-1:0]    r_ptr;
    logic [c_ID_W-1:0]    r_id;
    logic [BIT_WIDTH-1:0] r_a;
    logic [BIT_WIDTH-1:0] r_b;
    logic                 r_cin;
    resp_t                r_resp;
    logic                 r_resp_valid;
    logic                 r_busy;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_ID_W-1:0]    w_idx;
    logic                 w_any;
    logic [c_ID_W-1:0]    w_ptr_next;
    logic [BIT_WIDTH-1:0] w_a_arr [NUM_REQ];
    logic [BIT_WIDTH-1:0] w_b_arr [NUM_REQ];

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_a_arr[i] = req_a[i*BIT_WIDTH +: BIT_WIDTH];
            assign w_b_arr[i] = req_b[i*BIT_WIDTH +: BIT_WIDTH];
        end
    endgenerate

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (c_ID_W)
    ) u_picker (
        .valid (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .index (w_idx),
        .any   (w_any)
    );

    assign w_ptr_next = (w_idx == c_ID_W'(NUM_REQ - 1)) ? '0 : w_idx + c_ID_W'(1);

    // Grant is only offered from IDLE and never while reset is held.
    assign req_ready  = (r_state == ST_IDLE && !rst) ? w_grant : '0;

    assign add_a      = r_a;
    assign add_b      = r_b;
    assign add_cin    = r_cin;
    assign resp_valid = r_resp_valid;
    assign resp_sum   = r_resp.sum[BIT_WIDTH-1:0];
    assign resp_ovf   = r_resp.ovf;
    assign resp_id    = r_resp.id[c_ID_W-1:0];
    assign busy       = r_busy;

    // Upper bits of the shared response tuple stay zero at narrower widths.
    logic [$bits(resp_t)-1:0] w_resp_unused;
    assign w_resp_unused = r_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_cin        <= 1'b0;
            r_resp       <= '0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_a     <= w_a_arr[w_idx];
                        r_b     <= w_b_arr[w_idx];
                        r_cin   <= req_cin[w_idx];
                        r_id    <= w_idx;
                        r_ptr   <= w_ptr_next;
                        r_busy  <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_resp       <= pack_resp(c_MAX_BIT_WIDTH'(add_sum), add_ovf,
                                              c_MAX_ID_W'(r_id));
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
